// File: rtl/usage_sampler.sv
// Periodic sampler for a usage_counter: clears it, opens a sample window,
// waits for the counter pipeline to drain, then captures the count with overrun tracking.
module usage_sampler #(
  parameter int unsigned COUNT_W       = 16,
  parameter int unsigned WINDOW_W      = 16,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic               sysclk,
  input  logic               sysreset,
  input  logic               run,
  input  logic [WINDOW_W-1:0] window_cycles,
  input  logic [COUNT_W-1:0] counter_in,
  output logic               sample_enable,
  output logic               counter_reset,
  output logic [COUNT_W-1:0] result,
  output logic               result_valid,
  input  logic               result_ack,
  output logic               overrun,
  input  logic               overrun_clear,
  output logic [7:0]         window_seq
);

  // One down-counter serves both the window and the settle phase.
  localparam int unsigned CNT_W = (WINDOW_W > 4) ? WINDOW_W : 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    WINDOW  = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sample_enable_q, sample_enable_d;
  logic               counter_reset_q, counter_reset_d;
  logic [COUNT_W-1:0] result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic               overrun_q, overrun_d;
  logic [7:0]         window_seq_q, window_seq_d;
  logic               capture;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    result_d        = result_q;
    result_valid_d  = result_valid_q;
    overrun_d       = overrun_q;
    window_seq_d    = window_seq_q;
    capture         = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) state_d = CLEAR;
      end
      CLEAR: begin
        cnt_d   = (window_cycles == '0) ? CNT_W'(1) : CNT_W'(window_cycles);
        state_d = WINDOW;
      end
      WINDOW: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = CNT_W'(SETTLE_CYCLES);
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(1)) state_d = CAPTURE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = run ? CLEAR : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Overrun set takes priority over a simultaneous clear.
    if (overrun_clear) overrun_d = 1'b0;
    if (capture && result_valid_q && !result_ack) overrun_d = 1'b1;

    if (result_valid_q && result_ack) result_valid_d = 1'b0;
    if (capture) begin
      result_d       = counter_in;
      result_valid_d = 1'b1;
      window_seq_d   = window_seq_q + 8'd1;
    end

    // Outputs are registered copies of the upcoming state's decode.
    sample_enable_d = (state_d == WINDOW);
    counter_reset_d = (state_d == CLEAR);
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      sample_enable_q <= 1'b0;
      counter_reset_q <= 1'b0;
      result_q        <= '0;
      result_valid_q  <= 1'b0;
      overrun_q       <= 1'b0;
      window_seq_q    <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      sample_enable_q <= sample_enable_d;
      counter_reset_q <= counter_reset_d;
      result_q        <= result_d;
      result_valid_q  <= result_valid_d;
      overrun_q       <= overrun_d;
      window_seq_q    <= window_seq_d;
    end
  end

  assign sample_enable = sample_enable_q;
  assign counter_reset = counter_reset_q;
  assign result        = result_q;
  assign result_valid  = result_valid_q;
  assign overrun       = overrun_q;
  assign window_seq    = window_seq_q;

endmodule

// File: tb/tb_usage_sampler.sv
// Bench for usage_sampler: a loop-back usage counter plus a timeline reference model
// that predicts every output from the CLEAR cycle, window length and settle time.
module tb_usage_sampler;
  localparam int S = 2;

  logic        sysclk = 1'b0;
  logic        sysreset = 1'b1;
  logic        run = 1'b0;
  logic [15:0] window_cycles = '0;
  logic [15:0] counter_in;
  logic        sample_enable, counter_reset, result_valid, overrun;
  logic        result_ack = 1'b0, overrun_clear = 1'b0;
  logic [15:0] result;
  logic [7:0]  window_seq;
  logic        ev = 1'b0;
  logic [15:0] uc = '0;

  int total = 0, bad = 0, k = 0;
  // Timeline model: window k-indices derived from the CLEAR cycle m_c.
  bit m_idle, m_rv, m_ov;
  int m_c, m_n, m_cap, m_acc, m_res, m_seq;

  usage_sampler #(.COUNT_W(16), .WINDOW_W(16), .SETTLE_CYCLES(S)) dut (
    .sysclk(sysclk), .sysreset(sysreset), .run(run), .window_cycles(window_cycles),
    .counter_in(counter_in), .sample_enable(sample_enable), .counter_reset(counter_reset),
    .result(result), .result_valid(result_valid), .result_ack(result_ack),
    .overrun(overrun), .overrun_clear(overrun_clear), .window_seq(window_seq)
  );

  always #5 sysclk = ~sysclk;

  // Simple usage_counter: counts ev pulses while enabled, zeroed by counter_reset.
  always @(posedge sysclk) begin
    if (counter_reset) uc <= '0;
    else if (sample_enable && ev) uc <= uc + 16'd1;
  end
  assign counter_in = uc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, k, got, exp);
    end
  endtask

  function automatic bit m_cr();
    return !m_idle && k == m_c;
  endfunction

  function automatic bit m_se();
    return !m_idle && m_n > 0 && k > m_c && k <= m_c + m_n;
  endfunction

  task automatic m_reset();
    m_idle = 1; m_rv = 0; m_ov = 0; m_res = 0; m_seq = 0;
    m_c = -10; m_n = 0; m_cap = -1; m_acc = 0;
  endtask

  // Advance the model across the edge that ends cycle k, using the inputs now driven.
  task automatic model_edge();
    bit cap_now;
    if (sysreset) begin m_reset(); return; end
    cap_now = !m_idle && k == m_cap;
    if (!m_idle && k == m_c) begin
      m_n   = (window_cycles == 0) ? 1 : int'(window_cycles);
      m_cap = m_c + m_n + S + 1;
      m_acc = 0;
    end
    if (m_se() && ev) m_acc++;
    if (overrun_clear) m_ov = 0;
    if (cap_now && m_rv && !result_ack) m_ov = 1;
    if (m_rv && result_ack) m_rv = 0;
    if (cap_now) begin
      m_rv = 1; m_res = m_acc; m_seq = (m_seq + 1) % 256;
    end
    if (m_idle) begin
      if (run) begin m_idle = 0; m_c = k + 1; m_n = 0; m_cap = -1; end
    end else if (cap_now) begin
      if (run) begin m_c = k + 1; m_n = 0; m_cap = -1; end
      else m_idle = 1;
    end
  endtask

  task automatic check_outputs();
    check("counter_reset", counter_reset, m_cr());
    check("sample_enable", sample_enable, m_se());
    check("result_valid", result_valid, m_rv);
    check("overrun", overrun, m_ov);
    check("result", result, m_res);
    check("window_seq", window_seq, m_seq);
  endtask

  task automatic step();
    model_edge();
    @(posedge sysclk);
    k++;
    @(negedge sysclk);
    check_outputs();
  endtask

  task automatic pulse_reset();
    sysreset = 1'b1;
    #1;
    check("async_se", sample_enable, 0);
    check("async_cr", counter_reset, 0);
    check("async_rv", result_valid, 0);
    check("async_ov", overrun, 0);
    check("async_res", result, 0);
    check("async_seq", window_seq, 0);
    step();
    sysreset = 1'b0;
  endtask

  initial begin
    int se_cnt, t_cr, t_rv, seq0;
    m_reset();
    @(negedge sysclk);
    check_outputs();
    sysreset = 1'b0;

    // Three pulses inside an 8-cycle window, three outside.
    window_cycles = 16'd8; run = 1'b1;
    step();
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ev = (i == 2 || i == 4 || i == 6 || i == 0 || i == 9 || i == 13);
      step();
    end
    ev = 1'b0;
    check("loop_result", result, 3);
    check("loop_seq", window_seq, 1);
    result_ack = 1'b1; step(); result_ack = 1'b0;

    // Basic timing with window 5.
    window_cycles = 16'd5; run = 1'b1;
    se_cnt = 0; t_cr = -1; t_rv = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (counter_reset && t_cr < 0) begin t_cr = k; run = 1'b0; end
      if (sample_enable) se_cnt++;
      if (result_valid && t_rv < 0) t_rv = k;
    end
    check("se_len5", se_cnt, 5);
    check("rv_delay", t_rv - t_cr, 5 + S + 2);
    result_ack = 1'b1; step(); result_ack = 1'b0;

    // Two captures without ack set overrun; then clear it.
    window_cycles = 16'd3; run = 1'b1;
    for (int i = 0; i < 14; i++) begin ev = 1'($urandom); step(); end
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin ev = 1'($urandom); step(); end
    ev = 1'b0;
    check("ovr_set", overrun, 1);
    overrun_clear = 1'b1; step(); overrun_clear = 1'b0;
    check("ovr_clr", overrun, 0);

    // Ack coincident with CAPTURE keeps valid and no overrun.
    window_cycles = 16'd2; run = 1'b1;
    step();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      result_ack = (!m_idle && k == m_cap);
      step();
    end
    result_ack = 1'b0;
    check("ack_cap_rv", result_valid, 1);
    check("ack_cap_ov", overrun, 0);

    // Zero window length behaves as one cycle.
    window_cycles = 16'd0; run = 1'b1; se_cnt = 0;
    step();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); if (sample_enable) se_cnt++; end
    check("se_len0", se_cnt, 1);

    // run dropped at cycle 2 of a 10-cycle window.
    seq0 = int'(window_seq);
    window_cycles = 16'd10; run = 1'b1;
    step(); step(); step();
    run = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("drop_seq", window_seq, (seq0 + 1) % 256);
    check("drop_idle_se", sample_enable, 0);

    // Reset mid-window abandons the partial window.
    window_cycles = 16'd10; run = 1'b1;
    for (int i = 0; i < 4; i++) step();
    run = 1'b0;
    pulse_reset();
    for (int i = 0; i < 20; i++) step();
    check("rst_rv", result_valid, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      window_cycles = 16'($urandom_range(0, 6));
      ev = 1'($urandom);
      result_ack = ($urandom_range(0, 3) == 0);
      overrun_clear = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 399) == 0) pulse_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
